// File: rtl/operand_collector_if.sv
// Bundle of the issue, register-file and execute-side signals of the operand collector.
// The collector is the slave; the issue/RF/execute environment is the master.
interface operand_collector_if #(
    parameter int LANES  = 8,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6,
    parameter int WARP_W = 3,
    parameter int TAG_W  = 4
);
    // issue side
    logic                    iss_valid;
    logic                    iss_ready;
    logic [WARP_W-1:0]       iss_warp;
    logic [ADDR_W-1:0]       iss_rs0;
    logic [ADDR_W-1:0]       iss_rs1;
    logic                    iss_use0;
    logic                    iss_use1;
    logic [LANES-1:0]        iss_mask;
    logic [TAG_W-1:0]        iss_tag;

    // register_block / warp_selector side
    logic                    rf_grant;
    logic [LANES-1:0]        rf_read_en_0;
    logic [LANES-1:0]        rf_read_en_1;
    logic [ADDR_W-1:0]       rf_raddr_0;
    logic [ADDR_W-1:0]       rf_raddr_1;
    logic [WARP_W-1:0]       rf_warp_sel;
    logic [LANES*DATA_W-1:0] rf_rdata_0;
    logic [LANES*DATA_W-1:0] rf_rdata_1;

    // execute side
    logic                    ex_valid;
    logic                    ex_ready;
    logic [WARP_W-1:0]       ex_warp;
    logic [LANES-1:0]        ex_mask;
    logic [TAG_W-1:0]        ex_tag;
    logic [LANES*DATA_W-1:0] ex_opa;
    logic [LANES*DATA_W-1:0] ex_opb;

    modport slave (
        input  iss_valid, iss_warp, iss_rs0, iss_rs1, iss_use0, iss_use1, iss_mask, iss_tag,
        output iss_ready,
        input  rf_grant, rf_rdata_0, rf_rdata_1,
        output rf_read_en_0, rf_read_en_1, rf_raddr_0, rf_raddr_1, rf_warp_sel,
        input  ex_ready,
        output ex_valid, ex_warp, ex_mask, ex_tag, ex_opa, ex_opb
    );

    modport master (
        output iss_valid, iss_warp, iss_rs0, iss_rs1, iss_use0, iss_use1, iss_mask, iss_tag,
        input  iss_ready,
        output rf_grant, rf_rdata_0, rf_rdata_1,
        input  rf_read_en_0, rf_read_en_1, rf_raddr_0, rf_raddr_1, rf_warp_sel,
        output ex_ready,
        input  ex_valid, ex_warp, ex_mask, ex_tag, ex_opa, ex_opb
    );
endinterface

// File: rtl/operand_collector.sv
// Operand collector: reads both source registers of an issued warp instruction from the
// register file in the accept cycle, zeroes unused/inactive lanes, and queues the result
// in a DEPTH-entry FIFO towards execute with a valid/ready handshake.
module operand_collector #(
    parameter int LANES  = 8,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6,
    parameter int WARP_W = 3,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    operand_collector_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OP_W  = LANES * DATA_W;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

    logic [WARP_W-1:0] warp_q [DEPTH];
    logic [LANES-1:0]  mask_q [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [OP_W-1:0]   opa_q  [DEPTH];
    logic [OP_W-1:0]   opb_q  [DEPTH];

    logic [ADDR_W-1:0] raddr0_q, raddr1_q;
    logic [WARP_W-1:0] warp_sel_q;

    logic              has_entry;
    logic              full;
    logic              pop;
    logic              accept;
    logic [OP_W-1:0]   opa_new, opb_new;

    assign has_entry = (count_q != '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign pop       = has_entry && bus.ex_ready;
    // A full FIFO can still take an instruction when its head leaves in the same cycle.
    assign bus.iss_ready = !rst && !flush && bus.rf_grant && (!full || pop);
    assign accept        = bus.iss_valid && bus.iss_ready;

    // RF port drive: enables only in the accept cycle, address/warp hold otherwise
    always_comb begin
        bus.rf_read_en_0 = '0;
        bus.rf_read_en_1 = '0;
        bus.rf_raddr_0   = raddr0_q;
        bus.rf_raddr_1   = raddr1_q;
        bus.rf_warp_sel  = warp_sel_q;
        if (accept) begin
            bus.rf_read_en_0 = bus.iss_use0 ? bus.iss_mask : '0;
            bus.rf_read_en_1 = bus.iss_use1 ? bus.iss_mask : '0;
            bus.rf_raddr_0   = bus.iss_rs0;
            bus.rf_raddr_1   = bus.iss_rs1;
            bus.rf_warp_sel  = bus.iss_warp;
        end
    end

    // Per-lane operand capture: unused operand or inactive lane reads as zero
    always_comb begin
        opa_new = '0;
        opb_new = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (bus.iss_use0 && bus.iss_mask[l])
                opa_new[l*DATA_W +: DATA_W] = bus.rf_rdata_0[l*DATA_W +: DATA_W];
            if (bus.iss_use1 && bus.iss_mask[l])
                opb_new[l*DATA_W +: DATA_W] = bus.rf_rdata_1[l*DATA_W +: DATA_W];
        end
    end

    // FIFO occupancy and pointer next-state
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (accept)
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (accept && !pop)
                count_d = count_q + CNT_W'(1);
            else if (pop && !accept)
                count_d = count_q - CNT_W'(1);
        end
    end

    // State registers, entry storage and held RF address/warp
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            raddr0_q   <= '0;
            raddr1_q   <= '0;
            warp_sel_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                warp_q[i] <= '0;
                mask_q[i] <= '0;
                tag_q[i]  <= '0;
                opa_q[i]  <= '0;
                opb_q[i]  <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (accept) begin
                raddr0_q          <= bus.iss_rs0;
                raddr1_q          <= bus.iss_rs1;
                warp_sel_q        <= bus.iss_warp;
                warp_q[wr_ptr_q]  <= bus.iss_warp;
                mask_q[wr_ptr_q]  <= bus.iss_mask;
                tag_q[wr_ptr_q]   <= bus.iss_tag;
                opa_q[wr_ptr_q]   <= opa_new;
                opb_q[wr_ptr_q]   <= opb_new;
            end
        end
    end

    assign bus.ex_valid = has_entry;
    assign bus.ex_warp  = warp_q[rd_ptr_q];
    assign bus.ex_mask  = mask_q[rd_ptr_q];
    assign bus.ex_tag   = tag_q[rd_ptr_q];
    assign bus.ex_opa   = opa_q[rd_ptr_q];
    assign bus.ex_opb   = opb_q[rd_ptr_q];
endmodule

// File: tb/tb_operand_collector.sv
// Self-checking bench for operand_collector: a register-file model supplies per-lane data,
// accepted issues push expected entries to a scoreboard that is checked on each pop.
module tb_operand_collector;
    localparam int LANES  = 8;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 6;
    localparam int WARP_W = 3;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 2;
    localparam int OP_W   = LANES * DATA_W;

    typedef struct {
        logic [WARP_W-1:0] warp;
        logic [LANES-1:0]  mask;
        logic [TAG_W-1:0]  tag;
        logic [OP_W-1:0]   opa;
        logic [OP_W-1:0]   opb;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    operand_collector_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                           .WARP_W(WARP_W), .TAG_W(TAG_W)) bus ();

    operand_collector #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                        .WARP_W(WARP_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file contents: unique per warp/register/lane
    function automatic logic [63:0] rfval(logic [2:0] w, logic [5:0] a, int l);
        logic [31:0] h;
        h = (32'(w) * 32'h9E3779B1) ^ (32'(a) * 32'h85EBCA6B) ^ (32'(l + 1) * 32'hC2B2AE35);
        return {5'd0, w, 2'd0, a, 8'(l), 8'hC3, h};
    endfunction

    // Combinational register_block model
    always_comb begin
        bus.rf_rdata_0 = '0;
        bus.rf_rdata_1 = '0;
        for (int l = 0; l < LANES; l++) begin
            bus.rf_rdata_0[l*DATA_W +: DATA_W] = rfval(bus.rf_warp_sel, bus.rf_raddr_0, l);
            bus.rf_rdata_1[l*DATA_W +: DATA_W] = rfval(bus.rf_warp_sel, bus.rf_raddr_1, l);
        end
    end

    function automatic exp_t make_exp(logic [2:0] w, logic [5:0] r0, logic [5:0] r1,
                                      logic u0, logic u1, logic [7:0] m, logic [3:0] t);
        exp_t e;
        e.warp = w; e.mask = m; e.tag = t; e.opa = '0; e.opb = '0;
        for (int l = 0; l < LANES; l++) begin
            if (u0 && m[l]) e.opa[l*DATA_W +: DATA_W] = rfval(w, r0, l);
            if (u1 && m[l]) e.opb[l*DATA_W +: DATA_W] = rfval(w, r1, l);
        end
        return e;
    endfunction

    // Scoreboard: compare on pop, push on accept, sampled mid-cycle
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (bus.ex_valid && bus.ex_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: pop with tag %0h but nothing expected", bus.ex_tag);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.ex_warp !== e.warp || bus.ex_mask !== e.mask || bus.ex_tag !== e.tag) begin
                        errors++;
                        $display("FAIL sb_hdr: got warp %0h mask %h tag %0h, want warp %0h mask %h tag %0h",
                                 bus.ex_warp, bus.ex_mask, bus.ex_tag, e.warp, e.mask, e.tag);
                    end
                    checks++;
                    if (bus.ex_opa !== e.opa) begin
                        errors++;
                        $display("FAIL sb_opa tag %0h: got %h want %h", e.tag, bus.ex_opa, e.opa);
                    end
                    checks++;
                    if (bus.ex_opb !== e.opb) begin
                        errors++;
                        $display("FAIL sb_opb tag %0h: got %h want %h", e.tag, bus.ex_opb, e.opb);
                    end
                end
            end
            if (bus.iss_valid && bus.iss_ready)
                sb.push_back(make_exp(bus.iss_warp, bus.iss_rs0, bus.iss_rs1, bus.iss_use0,
                                      bus.iss_use1, bus.iss_mask, bus.iss_tag));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(logic [2:0] w, logic [5:0] r0, logic [5:0] r1, logic u0,
                             logic u1, logic [7:0] m, logic [3:0] t);
        bus.iss_valid = 1'b1;
        bus.iss_warp  = w;
        bus.iss_rs0   = r0;
        bus.iss_rs1   = r1;
        bus.iss_use0  = u0;
        bus.iss_use1  = u1;
        bus.iss_mask  = m;
        bus.iss_tag   = t;
    endtask

    task automatic drain();
        bus.iss_valid = 1'b0;
        bus.ex_ready  = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (sb.size() == 0 && !bus.ex_valid) break;
            tick();
        end
        checks++;
        if (sb.size() != 0 || bus.ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: ex_valid %b pending %0d, want 0 and 0", bus.ex_valid, sb.size());
        end
    endtask

    task automatic test_reset();
        // held in reset with a live request and grant
        set_issue(3'd1, 6'd2, 6'd3, 1'b1, 1'b1, 8'hFF, 4'd9);
        bus.rf_grant = 1'b1;
        #1;
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.iss_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: ex_valid %b iss_ready %b, want 0 0", bus.ex_valid, bus.iss_ready);
        end
        checks++;
        if (bus.rf_read_en_0 !== 8'h00 || bus.rf_read_en_1 !== 8'h00 || bus.rf_raddr_0 !== 6'd0 ||
            bus.rf_warp_sel !== 3'd0) begin
            errors++;
            $display("FAIL reset_rf: en0 %h en1 %h raddr0 %0d wsel %0d, want 0", bus.rf_read_en_0,
                     bus.rf_read_en_1, bus.rf_raddr_0, bus.rf_warp_sel);
        end
        checks++;
        if (bus.ex_opa !== '0 || bus.ex_opb !== '0 || bus.ex_tag !== 4'd0 || bus.ex_mask !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: ex_tag %0h ex_mask %h, operands nonzero or data not 0",
                     bus.ex_tag, bus.ex_mask);
        end
        bus.iss_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bus.ex_ready = 1'b1;
        set_issue(3'd3, 6'd5, 6'd9, 1'b1, 1'b1, 8'hFF, 4'd1);
        #1;
        checks++;
        if (bus.iss_ready !== 1'b1 || bus.rf_read_en_0 !== 8'hFF || bus.rf_read_en_1 !== 8'hFF) begin
            errors++;
            $display("FAIL single_en: ready %b en0 %h en1 %h, want 1 ff ff", bus.iss_ready,
                     bus.rf_read_en_0, bus.rf_read_en_1);
        end
        checks++;
        if (bus.rf_raddr_0 !== 6'd5 || bus.rf_raddr_1 !== 6'd9 || bus.rf_warp_sel !== 3'd3) begin
            errors++;
            $display("FAIL single_addr: raddr %0d/%0d wsel %0d, want 5/9 3", bus.rf_raddr_0,
                     bus.rf_raddr_1, bus.rf_warp_sel);
        end
        tick();
        bus.iss_valid = 1'b0;
        #1;
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_tag !== 4'd1 || bus.ex_opa[63:0] !== rfval(3'd3, 6'd5, 0)) begin
            errors++;
            $display("FAIL single_out: ex_valid %b tag %0h lane0 %h, want 1 1 %h", bus.ex_valid,
                     bus.ex_tag, bus.ex_opa[63:0], rfval(3'd3, 6'd5, 0));
        end
        checks++;
        if (bus.rf_read_en_0 !== 8'h00 || bus.rf_raddr_0 !== 6'd5 || bus.rf_raddr_1 !== 6'd9 ||
            bus.rf_warp_sel !== 3'd3) begin
            errors++;
            $display("FAIL single_hold: en0 %h raddr %0d/%0d wsel %0d, want 00 5/9 3",
                     bus.rf_read_en_0, bus.rf_raddr_0, bus.rf_raddr_1, bus.rf_warp_sel);
        end
        drain();
    endtask

    task automatic test_mask_use();
        bus.ex_ready = 1'b0;
        set_issue(3'd2, 6'd7, 6'd11, 1'b1, 1'b0, 8'h0F, 4'd5);
        #1;
        checks++;
        if (bus.rf_read_en_0 !== 8'h0F || bus.rf_read_en_1 !== 8'h00) begin
            errors++;
            $display("FAIL mask_en: en0 %h en1 %h, want 0f 00", bus.rf_read_en_0, bus.rf_read_en_1);
        end
        tick();
        bus.iss_valid = 1'b0;
        #1;
        checks++;
        if (bus.ex_opa[OP_W-1:OP_W/2] !== '0 || bus.ex_opb !== '0 ||
            bus.ex_opa[127:64] !== rfval(3'd2, 6'd7, 1)) begin
            errors++;
            $display("FAIL mask_ops: upper opa or opb nonzero, or lane1 %h want %h",
                     bus.ex_opa[127:64], rfval(3'd2, 6'd7, 1));
        end
        drain();
        // degenerate issues still create all-zero entries
        set_issue(3'd4, 6'd1, 6'd2, 1'b1, 1'b1, 8'h00, 4'd6);
        tick();
        set_issue(3'd5, 6'd3, 6'd4, 1'b0, 1'b0, 8'hFF, 4'd7);
        tick();
        drain();
    endtask

    task automatic test_backpressure();
        bus.ex_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            set_issue(3'(t + 1), 6'(10 + t), 6'(20 + t), 1'b1, 1'b1, 8'hA5, 4'(t));
            #1;
            checks++;
            if (bus.iss_ready !== (t < 2)) begin
                errors++;
                $display("FAIL bp_ready cycle %0d: iss_ready %b want %b", t, bus.iss_ready, t < 2);
            end
            checks++;
            if (t > 0 && bus.ex_tag !== 4'd0) begin
                errors++;
                $display("FAIL bp_stable cycle %0d: ex_tag %0h want 0", t, bus.ex_tag);
            end
            if (t < 2) tick();
        end
        bus.ex_ready = 1'b1;
        #1;
        checks++;
        if (bus.iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_pushpop: iss_ready %b want 1 when full and popping", bus.iss_ready);
        end
        tick();
        bus.iss_valid = 1'b0;
        #1;
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_tag !== 4'd1) begin
            errors++;
            $display("FAIL bp_order: ex_valid %b tag %0h, want 1 1", bus.ex_valid, bus.ex_tag);
        end
        drain();
    endtask

    task automatic test_no_grant();
        bus.rf_grant = 1'b0;
        set_issue(3'd6, 6'd33, 6'd44, 1'b1, 1'b1, 8'hFF, 4'd3);
        #1;
        checks++;
        if (bus.iss_ready !== 1'b0 || bus.rf_read_en_0 !== 8'h00 || bus.rf_read_en_1 !== 8'h00) begin
            errors++;
            $display("FAIL nogrant_rf: ready %b en0 %h en1 %h, want 0 00 00", bus.iss_ready,
                     bus.rf_read_en_0, bus.rf_read_en_1);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL nogrant_entry: ex_valid %b want 0", bus.ex_valid);
        end
        bus.iss_valid = 1'b0;
        bus.rf_grant  = 1'b1;
    endtask

    task automatic test_flush();
        bus.ex_ready = 1'b0;
        set_issue(3'd1, 6'd1, 6'd2, 1'b1, 1'b1, 8'hFF, 4'd8);
        tick();
        set_issue(3'd2, 6'd3, 6'd4, 1'b1, 1'b1, 8'hFF, 4'd9);
        tick();
        flush = 1'b1;
        set_issue(3'd3, 6'd5, 6'd6, 1'b1, 1'b1, 8'hFF, 4'd10);
        #1;
        checks++;
        if (bus.iss_ready !== 1'b0 || bus.rf_read_en_0 !== 8'h00 || bus.ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_cycle: ready %b en0 %h ex_valid %b, want 0 00 1", bus.iss_ready,
                     bus.rf_read_en_0, bus.ex_valid);
        end
        tick();
        flush = 1'b0;
        bus.iss_valid = 1'b0;
        #1;
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: ex_valid %b want 0", bus.ex_valid);
        end
        set_issue(3'd7, 6'd63, 6'd0, 1'b1, 1'b1, 8'h3C, 4'd11);
        tick();
        drain();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 80; c++) begin
            bus.rf_grant = ($urandom_range(0, 4) != 0);
            bus.ex_ready = $urandom_range(0, 1);
            set_issue(3'($urandom), 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
                      8'($urandom), 4'($urandom));
            bus.iss_valid = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.rf_grant = 1'b1;
        drain();
    endtask

    task automatic test_reset_mid();
        bus.ex_ready = 1'b0;
        set_issue(3'd4, 6'd8, 6'd9, 1'b1, 1'b1, 8'hFF, 4'd12);
        tick();
        set_issue(3'd5, 6'd10, 6'd11, 1'b1, 1'b1, 8'hFF, 4'd13);
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.iss_ready !== 1'b0 || bus.rf_read_en_0 !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_hs: ex_valid %b ready %b en0 %h, want 0 0 00", bus.ex_valid,
                     bus.iss_ready, bus.rf_read_en_0);
        end
        checks++;
        if (bus.ex_opa !== '0 || bus.ex_tag !== 4'd0 || bus.rf_raddr_0 !== 6'd0) begin
            errors++;
            $display("FAIL rstmid_data: ex_tag %0h raddr0 %0d or opa nonzero, want 0",
                     bus.ex_tag, bus.rf_raddr_0);
        end
        bus.iss_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        set_issue(3'd6, 6'd12, 6'd13, 1'b1, 1'b1, 8'h81, 4'd14);
        tick();
        drain();
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.iss_valid = 1'b0;
        bus.iss_warp  = '0;
        bus.iss_rs0   = '0;
        bus.iss_rs1   = '0;
        bus.iss_use0  = 1'b0;
        bus.iss_use1  = 1'b0;
        bus.iss_mask  = '0;
        bus.iss_tag   = '0;
        bus.rf_grant  = 1'b1;
        bus.ex_ready  = 1'b0;
        tick();
        test_reset();
        test_single();
        test_mask_use();
        test_backpressure();
        test_no_grant();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
